// File: rtl/memory_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : memory_cycle
//  Description : MEM stage of the RV32I 5-stage pipeline. It takes the EX/MEM
//                register, runs loads/stores on a req/ready data-memory port
//                with byte-lane steering and load sign/zero extension, and
//                drives the MEM/WB register. It raises stall_m while an
//                access is outstanding and aborts an access after TIMEOUT
//                wait cycles.
//  Ports       : clk, rst (async, active-high)
//                *_m        : EX/MEM register contents (inputs)
//                dmem_*     : data-memory request/response port
//                stall_m    : freeze upstream stages this cycle
//                *_w        : MEM/WB register towards write_back_cycle
//                misalign_err : one-cycle pulse as a misaligned op enters WB
//                bus_err    : sticky timeout flag, cleared only by rst
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_cycle #(
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] RESET_PC4 = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write_m,
    input  logic [1:0]  write_back_m,
    input  logic        mem_write_m,
    input  logic [2:0]  funct3_m,
    input  logic [31:0] alu_out_m,
    input  logic [31:0] write_data_m,
    input  logic [31:0] pc4_m,
    input  logic [4:0]  rd_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall_m,
    output logic        reg_write_w,
    output logic [1:0]  write_back_w,
    output logic [31:0] alu_out_w,
    output logic [31:0] mem_data_w,
    output logic [31:0] pc4_w,
    output logic [4:0]  rd_w,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           reg_write_q;
    logic [1:0]     write_back_q;
    logic [31:0]    alu_out_q;
    logic [31:0]    mem_data_q;
    logic [31:0]    pc4_q;
    logic [4:0]     rd_q;
    logic           misalign_q;
    logic           bus_err_q;

    logic           w_is_load;
    logic           w_access;
    logic           w_misalign;
    logic           w_aligned;
    logic           w_abort;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;
    logic [31:0]    w_load_ext;

    assign w_is_load  = (write_back_m == 2'b01);
    assign w_access   = w_is_load | mem_write_m;
    assign w_misalign = w_access &
                        (((funct3_m[1:0] == 2'b01) & alu_out_m[0]) |
                         ((funct3_m[1:0] == 2'b10) & (alu_out_m[1:0] != 2'b00)));
    assign w_aligned  = w_access & ~w_misalign;

    // Request and stall are gated by rst so an asserted reset forces them
    // low immediately even though the frozen EX/MEM inputs still show an access.
    assign dmem_req  = w_aligned & ~rst;
    assign stall_m   = w_aligned & ~dmem_ready & ~w_abort & ~rst;
    assign dmem_we   = w_aligned & mem_write_m;
    assign dmem_addr = {alu_out_m[31:2], 2'b00};

    // Store lane steering; loads always request the full word.
    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = write_data_m;
        if (mem_write_m) begin
            case (funct3_m[1:0])
                2'b00: begin
                    dmem_be    = 4'b0001 << alu_out_m[1:0];
                    dmem_wdata = {4{write_data_m[7:0]}};
                end
                2'b01: begin
                    dmem_be    = alu_out_m[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata = {2{write_data_m[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = write_data_m;
                end
            endcase
        end
    end

    // Load lane extraction and extension; undefined funct3 values act as LW.
    always_comb begin
        case (alu_out_m[1:0])
            2'b00:   w_byte = dmem_rdata[7:0];
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = alu_out_m[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_m)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_ext = {24'h0, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_ext = {16'h0, w_half};
            default: w_load_ext = dmem_rdata;
        endcase
    end

    // Wait-state controller: IDLE issues the access, WAIT counts until
    // ready arrives or the timeout expires.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_aligned && !dmem_ready) begin
                    state_d = WAIT;
                    cnt_d   = CW'(1);
                end
            end
            WAIT: begin
                if (dmem_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    w_abort = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MEM/WB register: a bubble is inserted while stalled; the data fields
    // simply hold since a bubble never writes the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            write_back_q <= 2'b00;
            alu_out_q    <= 32'h0;
            mem_data_q   <= 32'h0;
            pc4_q        <= RESET_PC4;
            rd_q         <= 5'd0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            if (w_abort) begin
                bus_err_q <= 1'b1;
            end
            if (stall_m) begin
                reg_write_q  <= 1'b0;
                write_back_q <= 2'b00;
                rd_q         <= 5'd0;
                misalign_q   <= 1'b0;
            end else begin
                reg_write_q  <= reg_write_m & ~w_misalign & ~w_abort;
                write_back_q <= write_back_m;
                alu_out_q    <= alu_out_m;
                mem_data_q   <= w_abort ? 32'h0 : w_load_ext;
                pc4_q        <= pc4_m;
                rd_q         <= rd_m;
                misalign_q   <= w_misalign;
            end
        end
    end

    assign reg_write_w  = reg_write_q;
    assign write_back_w = write_back_q;
    assign alu_out_w    = alu_out_q;
    assign mem_data_w   = mem_data_q;
    assign pc4_w        = pc4_q;
    assign rd_w         = rd_q;
    assign misalign_err = misalign_q;
    assign bus_err      = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_cycle
//  Description : Self-checking bench for memory_cycle. Each issued
//                instruction pushes its expected MEM/WB contents to a queue;
//                the entry is popped and compared when the stage completes.
//                A latency-programmable memory responder drives dmem_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_cycle;

    localparam int          TO    = 16;
    localparam logic [31:0] RPC4  = 32'h0000_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write_m;
    logic [1:0]  write_back_m;
    logic        mem_write_m;
    logic [2:0]  funct3_m;
    logic [31:0] alu_out_m;
    logic [31:0] write_data_m;
    logic [31:0] pc4_m;
    logic [4:0]  rd_m;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        stall_m;
    logic        reg_write_w;
    logic [1:0]  write_back_w;
    logic [31:0] alu_out_w;
    logic [31:0] mem_data_w;
    logic [31:0] pc4_w;
    logic [4:0]  rd_w;
    logic        misalign_err;
    logic        bus_err;

    memory_cycle #(.TIMEOUT(TO), .RESET_PC4(RPC4)) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_write_m  (reg_write_m),
        .write_back_m (write_back_m),
        .mem_write_m  (mem_write_m),
        .funct3_m     (funct3_m),
        .alu_out_m    (alu_out_m),
        .write_data_m (write_data_m),
        .pc4_m        (pc4_m),
        .rd_m         (rd_m),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_rdata   (dmem_rdata),
        .dmem_ready   (dmem_ready),
        .stall_m      (stall_m),
        .reg_write_w  (reg_write_w),
        .write_back_w (write_back_w),
        .alu_out_w    (alu_out_w),
        .mem_data_w   (mem_data_w),
        .pc4_w        (pc4_w),
        .rd_w         (rd_w),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [31:0] md;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        mis;
        logic        ld;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference load extension built from shifts of the read word.
    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = rd >> {a[1:0], 3'b000};
        h = rd >> {a[1], 4'b0000};
        case (f3)
            3'b000:  return {{24{b[7]}}, b[7:0]};
            3'b100:  return {24'h0, b[7:0]};
            3'b001:  return {{16{h[15]}}, h[15:0]};
            3'b101:  return {16'h0, h[15:0]};
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] be_model(input logic mw, input logic [2:0] f3, input logic [31:0] a);
        if (!mw)                return 4'b1111;
        if (f3[1:0] == 2'b00)   return 4'(4'b0001 << a[1:0]);
        if (f3[1:0] == 2'b01)   return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] wd_model(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (f3[1:0] == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    // Drive one instruction; the responder raises dmem_ready on wait cycle
    // 'lat' (0 = same cycle). A lat above TO never answers.
    task automatic issue(input logic rw, input logic [1:0] wb, input logic mw,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] pc4, input logic [4:0] rd,
                         input logic [31:0] rdata, input int lat);
        exp_t e;
        exp_t g;
        logic acc, mis, al, to, st;
        int   k;
        int   stalls;
        acc = (wb == 2'b01) | mw;
        mis = acc & (((f3[1:0] == 2'b01) & addr[0]) |
                     ((f3[1:0] == 2'b10) & (addr[1:0] != 2'b00)));
        al  = acc & ~mis;
        to  = al & (lat > TO);
        e.rw  = rw & ~mis & ~to;
        e.wb  = wb;
        e.alu = addr;
        e.md  = to ? 32'h0 : load_model(f3, addr, rdata);
        e.pc4 = pc4;
        e.rd  = rd;
        e.mis = mis;
        e.ld  = (wb == 2'b01);
        sb.push_back(e);

        reg_write_m  = rw;
        write_back_m = wb;
        mem_write_m  = mw;
        funct3_m     = f3;
        alu_out_m    = addr;
        write_data_m = wd;
        pc4_m        = pc4;
        rd_m         = rd;
        dmem_rdata   = rdata;
        k      = 0;
        stalls = 0;
        while (1) begin
            dmem_ready = (k == lat);
            #1;
            if (k == 0) begin
                chk("dmem_req", 32'(dmem_req), 32'(al));
                if (al) begin
                    chk("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
                    chk("dmem_we", 32'(dmem_we), 32'(mw));
                    chk("dmem_be", 32'(dmem_be), 32'(be_model(mw, f3, addr)));
                    if (mw) chk("dmem_wdata", dmem_wdata, wd_model(f3, wd));
                end
            end else begin
                chk("req_held", 32'(dmem_req), 32'(1));
            end
            st = stall_m;
            @(posedge clk);
            #1;
            if (!st) break;
            stalls++;
            chk("bubble_rw", 32'(reg_write_w), 32'(0));
            chk("bubble_rd", 32'(rd_w), 32'(0));
            k++;
            if (k > 40) begin
                chk("stall_bound", 32'(1), 32'(0));
                break;
            end
        end
        dmem_ready = 1'b0;
        chk("stall_cycles", 32'(stalls), 32'(al ? ((lat > TO) ? TO : lat) : 0));
        g = sb.pop_front();
        chk("reg_write_w", 32'(reg_write_w), 32'(g.rw));
        chk("write_back_w", 32'(write_back_w), 32'(g.wb));
        chk("rd_w", 32'(rd_w), 32'(g.rd));
        chk("alu_out_w", alu_out_w, g.alu);
        chk("pc4_w", pc4_w, g.pc4);
        chk("misalign_err", 32'(misalign_err), 32'(g.mis));
        if (g.ld) chk("mem_data_w", mem_data_w, g.md);
    endtask

    initial begin
        rst = 1'b1;
        reg_write_m = 0; write_back_m = 0; mem_write_m = 0; funct3_m = 0;
        alu_out_m = 0; write_data_m = 0; pc4_m = 0; rd_m = 0;
        dmem_rdata = 0; dmem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc4", pc4_w, RPC4);
        chk("rst_rw", 32'(reg_write_w), 32'(0));
        chk("rst_bus_err", 32'(bus_err), 32'(0));
        chk("rst_req", 32'(dmem_req), 32'(0));
        rst = 1'b0;

        // Zero-wait loads with lane extraction and extension.
        issue(1, 2'b01, 0, 3'b010, 32'h100, 0, 32'h104, 5'd5, 32'hDEADBEEF, 0);
        chk("lw_tp", mem_data_w, 32'hDEADBEEF);
        issue(1, 2'b01, 0, 3'b000, 32'h103, 0, 32'h108, 5'd6, 32'h80123456, 0);
        chk("lb_tp", mem_data_w, 32'hFFFFFF80);
        issue(1, 2'b01, 0, 3'b100, 32'h103, 0, 32'h10C, 5'd7, 32'h80123456, 0);
        chk("lbu_tp", mem_data_w, 32'h00000080);
        issue(1, 2'b01, 0, 3'b101, 32'h102, 0, 32'h110, 5'd8, 32'h80123456, 0);
        chk("lhu_tp", mem_data_w, 32'h00008012);
        issue(1, 2'b01, 0, 3'b001, 32'h100, 0, 32'h114, 5'd9, 32'h1234F00D, 1);
        issue(1, 2'b01, 0, 3'b111, 32'h104, 0, 32'h118, 5'd3, 32'hCAFEF00D, 0);

        // Stores, ALU and JAL pass-through.
        issue(0, 2'b00, 1, 3'b001, 32'h206, 32'h0000ABCD, 32'h11C, 5'd0, 0, 0);
        issue(0, 2'b00, 1, 3'b000, 32'h209, 32'h000000A5, 32'h120, 5'd0, 0, 2);
        issue(0, 2'b00, 1, 3'b010, 32'h20C, 32'h13579BDF, 32'h124, 5'd0, 0, 1);
        issue(1, 2'b00, 0, 3'b000, 32'h55AA55AA, 0, 32'h128, 5'd10, 0, 0);
        issue(1, 2'b10, 0, 3'b000, 32'h0, 0, 32'h12C, 5'd1, 0, 0);

        // Three wait cycles.
        issue(1, 2'b01, 0, 3'b010, 32'h300, 0, 32'h130, 5'd11, 32'h0BADCAFE, 3);

        // Randomised loads and stores with short latencies.
        for (int i = 0; i < 12; i++) begin
            logic [2:0] f3;
            logic       st;
            st = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                default: f3 = 3'b101;
            endcase
            if (st) f3[2] = 1'b0;
            issue(!st, st ? 2'b00 : 2'b01, st, f3, $urandom, $urandom, $urandom,
                  5'($urandom), $urandom, $urandom_range(0, 4));
        end

        // Misaligned accesses: no request, no stall, one-cycle pulse.
        issue(1, 2'b01, 0, 3'b010, 32'h102, 0, 32'h140, 5'd12, 32'h11111111, 0);
        issue(1, 2'b00, 0, 3'b000, 32'h0, 0, 32'h144, 5'd13, 0, 0);
        issue(0, 2'b00, 1, 3'b001, 32'h101, 32'hFFFF, 32'h148, 5'd0, 0, 0);
        issue(1, 2'b01, 0, 3'b001, 32'h102, 0, 32'h14C, 5'd14, 32'h8000_0000, 0);

        // Timeout: never ready.
        chk("bus_err_pre", 32'(bus_err), 32'(0));
        issue(1, 2'b01, 0, 3'b010, 32'h400, 0, 32'h150, 5'd15, 32'h77777777, 100);
        chk("bus_err_set", 32'(bus_err), 32'(1));
        issue(1, 2'b00, 0, 3'b000, 32'hABCD0123, 0, 32'h154, 5'd16, 0, 0);
        chk("bus_err_sticky", 32'(bus_err), 32'(1));

        // Asynchronous reset in the middle of a wait.
        reg_write_m = 1; write_back_m = 2'b01; mem_write_m = 0; funct3_m = 3'b010;
        alu_out_m = 32'h500; pc4_m = 32'h158; rd_m = 5'd17; dmem_ready = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_stall", 32'(stall_m), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_stall", 32'(stall_m), 32'(0));
        chk("arst_req", 32'(dmem_req), 32'(0));
        chk("arst_pc4", pc4_w, RPC4);
        chk("arst_alu", alu_out_w, 32'h0);
        chk("arst_md", mem_data_w, 32'h0);
        chk("arst_bus_err", 32'(bus_err), 32'(0));
        chk("arst_rw", 32'(reg_write_w), 32'(0));
        reg_write_m = 0; write_back_m = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(1, 2'b01, 0, 3'b010, 32'h600, 0, 32'h160, 5'd18, 32'h600DF00D, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
